// File: rtl/uart_tx_frame_if.sv
// Request/status bundle between a frame producer and uart_tx_frame.
// The producer (master) drives the frame request; the transmitter (slave) reports busy/done.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 send;
  logic [DATA_BITS-1:0] data_in;
  logic                 parity_type;
  logic                 stop_bits;
  logic                 busy;
  logic                 done;

  modport master (
    output send,
    output data_in,
    output parity_type,
    output stop_bits,
    input  busy,
    input  done
  );

  modport slave (
    input  send,
    input  data_in,
    input  parity_type,
    input  stop_bits,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, DATA_BITS data bits LSB first, optional parity, one or two stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (even/odd selected per frame by parity_type).
module uart_tx_frame #(
  parameter int DATA_BITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  output logic             tx_out,
  uart_tx_frame_if.slave   bus
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PEND   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_two;
  logic                 stop_second;
  logic                 busy;
  logic                 done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`else
  logic                 unused_parity_type;
  assign unused_parity_type = bus.parity_type;
`endif

  assign bus.busy = busy;
  assign bus.done = done;

  // Every output is a flop; each line value appears the cycle after the Tick that selects it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      stop_two    <= 1'b0;
      stop_second <= 1'b0;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (bus.send) begin
            shift_reg <= bus.data_in;
            stop_two  <= bus.stop_bits;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^bus.data_in) ^ bus.parity_type;
`endif
            busy  <= 1'b1;
            state <= PEND;
          end
        end
        PEND: begin
          if (tick) begin
            tx_out <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_out <= parity_bit;
              state  <= PARITY;
`else
              tx_out      <= 1'b1;
              stop_second <= 1'b0;
              state       <= STOP;
`endif
            end else begin
              tx_out    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_out      <= 1'b1;
            stop_second <= 1'b0;
            state       <= STOP;
          end
        end
`endif
        STOP: begin
          // A second stop interval is only inserted when the frame latched stop_bits=1.
          if (tick) begin
            if (stop_two && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame; expected line sequences are hand-computed for both
// the default build and the UART_TX_PARITY_EN build.
module tb_uart_tx_frame;

  localparam int DATA_BITS = 8;
  localparam int TICK_GAP  = 15;

  // Expected line value after each Tick, transmission order left to right (start .. last stop).
`ifdef UART_TX_PARITY_EN
  localparam int          LEN_A = 11;
  localparam logic [11:0] SEQ_A = 12'b0_01010010101;
  localparam int          LEN_B = 12;
  localparam logic [11:0] SEQ_B = 12'b010100101111;
  localparam int          LEN_C = 11;
  localparam logic [11:0] SEQ_C = 12'b0_00000000001;
  localparam int          LEN_D = 11;
  localparam logic [11:0] SEQ_D = 12'b0_00011110001;
  localparam int          LEN_E = 11;
  localparam logic [11:0] SEQ_E = 12'b0_01010101001;
`else
  localparam int          LEN_A = 10;
  localparam logic [11:0] SEQ_A = 12'b00_0101001011;
  localparam int          LEN_B = 11;
  localparam logic [11:0] SEQ_B = 12'b0_01010010111;
  localparam int          LEN_C = 10;
  localparam logic [11:0] SEQ_C = 12'b00_0000000001;
  localparam int          LEN_D = 10;
  localparam logic [11:0] SEQ_D = 12'b00_0001111001;
  localparam int          LEN_E = 10;
  localparam logic [11:0] SEQ_E = 12'b00_0101010101;
`endif

  logic clock = 1'b0;
  logic reset;
  logic tick;
  logic tx_out;
  logic inject;
  int   vectors = 0;
  int   miscompares = 0;

  uart_tx_frame_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_tx_frame #(.DATA_BITS(DATA_BITS)) dut (
    .clock  (clock),
    .reset  (reset),
    .tick   (tick),
    .tx_out (tx_out),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic tx, input logic bsy, input logic dn);
    check({tag, " tx_out"}, 32'(tx_out), 32'(tx));
    check({tag, " busy"}, 32'(bus.busy), 32'(bsy));
    check({tag, " done"}, 32'(bus.done), 32'(dn));
  endtask

  task automatic accept(input logic [7:0] data, input logic ptype, input logic sbits,
                        input logic with_tick, input logic hold, input string tag);
    bus.send        = 1'b1;
    bus.data_in     = data;
    bus.parity_type = ptype;
    bus.stop_bits   = sbits;
    tick            = with_tick;
    step();
    bus.send = hold;
    tick     = 1'b0;
    check_line({tag, " accept"}, 1'b1, 1'b1, 1'b0);
    repeat (TICK_GAP) step();
    check_line({tag, " pend"}, 1'b1, 1'b1, 1'b0);
  endtask

  // One bit interval: Tick pulse, then the line must hold its value until the next Tick.
  task automatic tick_bit(input logic exp, input string tag);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_line({tag, " bit"}, exp, 1'b1, 1'b0);
    for (int c = 0; c < TICK_GAP; c++) begin
      if (inject && c == 0) begin
        bus.send    = 1'b1;
        bus.data_in = 8'hFF;
      end else if (inject && c == 1) begin
        bus.send    = 1'b0;
        bus.data_in = 8'h00;
      end
      step();
    end
    check({tag, " hold"}, 32'(tx_out), 32'(exp));
  endtask

  task automatic run_frame(input logic [11:0] seq, input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) tick_bit(seq[i], tag);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_line({tag, " end"}, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic after_frame(input string tag);
    step();
    check_line({tag, " idle"}, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    tick            = 1'b0;
    inject          = 1'b0;
    bus.send        = 1'b0;
    bus.data_in     = 8'h00;
    bus.parity_type = 1'b0;
    bus.stop_bits   = 1'b0;

    step();
    check_line("reset", 1'b1, 1'b0, 1'b0);
    // Reset wins over a simultaneous Send and Tick.
    bus.send = 1'b1;
    tick     = 1'b1;
    step();
    check_line("reset_prio", 1'b1, 1'b0, 1'b0);
    bus.send = 1'b0;
    tick     = 1'b0;
    reset    = 1'b0;
    step();

    tick = 1'b1;
    step();
    tick = 1'b0;
    check_line("idle_tick", 1'b1, 1'b0, 1'b0);

    accept(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "frameA");
    run_frame(SEQ_A, LEN_A, "frameA");
    after_frame("frameA");

    accept(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, "frameB");
    run_frame(SEQ_B, LEN_B, "frameB");
    after_frame("frameB");

    accept(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "frameC");
    inject = 1'b1;
    run_frame(SEQ_C, LEN_C, "frameC");
    inject = 1'b0;
    after_frame("frameC");

    // Abort after the 4th data bit (d3) of 0xA5 is on the line.
    accept(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "abort");
    tick_bit(1'b0, "abort start");
    tick_bit(1'b1, "abort d0");
    tick_bit(1'b0, "abort d1");
    tick_bit(1'b1, "abort d2");
    tick_bit(1'b0, "abort d3");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_line("abort reset", 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check_line("abort after", 1'b1, 1'b0, 1'b0);
      repeat (TICK_GAP) step();
    end

    accept(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "frameD");
    run_frame(SEQ_D, LEN_D, "frameD");
    after_frame("frameD");

    // Send held high: the Done cycle itself accepts the next frame.
    accept(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, "frameE1");
    run_frame(SEQ_E, LEN_E, "frameE1");
    step();
    check_line("frameE rearm", 1'b1, 1'b1, 1'b0);
    repeat (TICK_GAP - 1) step();
    run_frame(SEQ_E, LEN_E, "frameE2");
    bus.send = 1'b0;
    after_frame("frameE2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
